tlp_tx_arbiter: RTL and testbench

Schedules three TLP transmit request sources (Posted, Non-Posted, Completion) onto the single TX header path. It gates each class on PCIe flow-control header and data credits, and arbitrates eligible classes round-robin. It tracks available credits from the link-layer init and update pulses, and presents one registered header per grant with a valid/ready handshake toward the framer.

---
 rtl/tlp_pkg.sv | 44 ++++
 rtl/tlp_credit_counter.sv | 59 +++++
 rtl/tlp_tx_arbiter.sv | 144 ++++++++++++++
 tb/tb_tlp_tx_arbiter.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/tlp_pkg.sv
// Shared TLP encodings and the data-credit helper for the TX arbiter.
package tlp_pkg;

  localparam int NUM_CLS = 3;

  typedef enum logic [1:0] {
    CLS_P   = 2'd0,
    CLS_NP  = 2'd1,
    CLS_CPL = 2'd2
  } tlp_cls_e;

  localparam logic [2:0] FMT_3DW_NODATA = 3'b000;
  localparam logic [2:0] FMT_3DW_DATA   = 3'b010;
  localparam logic [2:0] FMT_4DW_NODATA = 3'b001;
  localparam logic [2:0] FMT_4DW_DATA   = 3'b011;
  localparam logic [2:0] FMT_PREFIX     = 3'b100;

  localparam logic [4:0] TYPE_MRD      = 5'b00000;
  localparam logic [4:0] TYPE_MRDLK    = 5'b00001;
  localparam logic [4:0] TYPE_IORDWR   = 5'b00010;
  localparam logic [4:0] TYPE_CFG0     = 5'b00100;
  localparam logic [4:0] TYPE_CPL      = 5'b01010;
  localparam logic [4:0] TYPE_CPLLK    = 5'b01011;
  localparam logic [4:0] TYPE_FETCHADD = 5'b01100;
  localparam logic [4:0] TYPE_SWAP     = 5'b01101;
  localparam logic [4:0] TYPE_CAS      = 5'b01110;

  typedef struct packed {
    logic [2:0] fmt;
    logic [4:0] typ;
    logic [9:0] len;
    logic [1:0] cls;
  } tlp_hdr_t;

  // Data credits for one TLP: ceil(len/4) DW quads; Length 0 encodes 1024 DW.
  function automatic logic [8:0] data_credits(input logic [2:0] fmt, input logic [9:0] len);
    logic [10:0] l;
    l = {1'b0, len} + 11'd3;
    if (!fmt[1])       return 9'd0;
    else if (len == '0) return 9'd256;
    else               return l[10:2];
  endfunction

endpackage

// File: rtl/tlp_credit_counter.sv
// One flow-control credit counter: init load (0 = infinite), net update/deduct,
// saturation with sticky overflow.
module tlp_credit_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         upd_i,
  input  logic [W-1:0] upd_val_i,
  input  logic         deduct_i,
  input  logic [W-1:0] need_i,
  output logic         ok_o,
  output logic         ovf_o
);

  logic [W-1:0] cnt_q, cnt_d;
  logic         inf_q, inf_d;
  logic         ovf_q, ovf_d;
  logic [W+1:0] net;

  always_comb begin
    cnt_d = cnt_q;
    inf_d = inf_q;
    ovf_d = ovf_q;
    // Deduct is only asserted when ok_o, so net never goes negative.
    net = {2'b00, cnt_q}
        + (upd_i    ? {2'b00, upd_val_i} : '0)
        - (deduct_i ? {2'b00, need_i}    : '0);
    if (load_i) begin
      cnt_d = load_val_i;
      inf_d = (load_val_i == '0);
    end else if (!inf_q) begin
      if (net > {2'b00, {W{1'b1}}}) begin
        cnt_d = '1;
        ovf_d = 1'b1;
      end else begin
        cnt_d = net[W-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
      inf_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      inf_q <= inf_d;
      ovf_q <= ovf_d;
    end
  end

  assign ok_o  = inf_q | (cnt_q >= need_i);
  assign ovf_o = ovf_q;

endmodule

// File: rtl/tlp_tx_arbiter.sv
// Credit-gated round-robin scheduler of P / NP / CPL TLP headers onto the TX
// header path; one registered header per grant, valid/ready toward the framer.
module tlp_tx_arbiter
  import tlp_pkg::*;
#(
  parameter int HDR_CW  = 8,
  parameter int DATA_CW = 12
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [2:0]             req_valid,
  input  logic [8:0]             req_fmt,
  input  logic [14:0]            req_type,
  input  logic [29:0]            req_len,
  output logic [2:0]             req_ready,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [2:0]             out_fmt,
  output logic [4:0]             out_type,
  output logic [9:0]             out_len,
  output logic [1:0]             out_class,
  input  logic                   fc_init_valid,
  input  logic [3*HDR_CW-1:0]    fc_init_hdr,
  input  logic [3*DATA_CW-1:0]   fc_init_data,
  input  logic                   fc_upd_valid,
  input  logic [1:0]             fc_upd_class,
  input  logic [HDR_CW-1:0]      fc_upd_hdr,
  input  logic [DATA_CW-1:0]     fc_upd_data,
  output logic                   fc_ready,
  output logic                   fc_overflow
);

  typedef enum logic {ST_IDLE, ST_SEND} st_e;

  st_e                           st_q, st_d;
  logic [1:0]                    rr_q, rr_d;
  tlp_hdr_t                      hdr_q, hdr_d;
  logic                          fc_ready_q;
  logic                          init_ld;
  logic [2:0]                    hdr_ok, data_ok, hdr_ovf, data_ovf;
  logic [2:0]                    upd_hit, elig, grant;
  logic [2:0][DATA_CW-1:0]       data_need;
  logic [1:0]                    win;
  logic                          any_elig;

  // Init is accepted exactly once, until the next reset.
  assign init_ld = fc_init_valid & ~fc_ready_q;

  for (genvar c = 0; c < NUM_CLS; c++) begin : g_cls
    assign data_need[c] = DATA_CW'(data_credits(req_fmt[3*c +: 3], req_len[10*c +: 10]));
    assign upd_hit[c]   = fc_upd_valid & (fc_upd_class == 2'(c));
    assign elig[c]      = rst_n & fc_ready_q & req_valid[c] & hdr_ok[c] & data_ok[c];

    tlp_credit_counter #(.W(HDR_CW)) u_hdr (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_i     (init_ld),
      .load_val_i (fc_init_hdr[HDR_CW*c +: HDR_CW]),
      .upd_i      (upd_hit[c]),
      .upd_val_i  (fc_upd_hdr),
      .deduct_i   (grant[c]),
      .need_i     (HDR_CW'(1)),
      .ok_o       (hdr_ok[c]),
      .ovf_o      (hdr_ovf[c])
    );

    tlp_credit_counter #(.W(DATA_CW)) u_data (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_i     (init_ld),
      .load_val_i (fc_init_data[DATA_CW*c +: DATA_CW]),
      .upd_i      (upd_hit[c]),
      .upd_val_i  (fc_upd_data),
      .deduct_i   (grant[c]),
      .need_i     (data_need[c]),
      .ok_o       (data_ok[c]),
      .ovf_o      (data_ovf[c])
    );
  end

  // First eligible class at or after the RR pointer, wrapping P -> NP -> CPL.
  always_comb begin
    int idx;
    idx      = 0;
    any_elig = 1'b0;
    win      = rr_q;
    for (int k = 0; k < NUM_CLS; k++) begin
      idx = int'(rr_q) + k;
      if (idx >= NUM_CLS) idx = idx - NUM_CLS;
      if (!any_elig && elig[idx]) begin
        any_elig = 1'b1;
        win      = 2'(idx);
      end
    end
  end

  always_comb begin
    st_d  = st_q;
    rr_d  = rr_q;
    hdr_d = hdr_q;
    grant = '0;
    case (st_q)
      ST_IDLE: begin
        if (any_elig) begin
          grant[win] = 1'b1;
          hdr_d.fmt  = req_fmt[3*win +: 3];
          hdr_d.typ  = req_type[5*win +: 5];
          hdr_d.len  = req_len[10*win +: 10];
          hdr_d.cls  = win;
          rr_d       = (win == 2'd2) ? 2'd0 : win + 2'd1;
          st_d       = ST_SEND;
        end
      end
      ST_SEND: begin
        if (out_ready) st_d = ST_IDLE;
      end
      default: st_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st_q       <= ST_IDLE;
      rr_q       <= 2'd0;
      hdr_q      <= '0;
      fc_ready_q <= 1'b0;
    end else begin
      st_q       <= st_d;
      rr_q       <= rr_d;
      hdr_q      <= hdr_d;
      fc_ready_q <= fc_ready_q | fc_init_valid;
    end
  end

  assign req_ready   = grant;
  assign out_valid   = (st_q == ST_SEND);
  assign out_fmt     = hdr_q.fmt;
  assign out_type    = hdr_q.typ;
  assign out_len     = hdr_q.len;
  assign out_class   = hdr_q.cls;
  assign fc_ready    = fc_ready_q;
  assign fc_overflow = |{hdr_ovf, data_ovf};

endmodule

// File: tb/tb_tlp_tx_arbiter.sv
// Directed bench for tlp_tx_arbiter: inputs change 1 ns after posedge,
// outputs are sampled on the following negedge.
module tb_tlp_tx_arbiter;
  import tlp_pkg::*;

  localparam int HDR_CW  = 8;
  localparam int DATA_CW = 12;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [2:0]           req_valid;
  logic [8:0]           req_fmt;
  logic [14:0]          req_type;
  logic [29:0]          req_len;
  logic [2:0]           req_ready;
  logic                 out_valid, out_ready;
  logic [2:0]           out_fmt;
  logic [4:0]           out_type;
  logic [9:0]           out_len;
  logic [1:0]           out_class;
  logic                 fc_init_valid;
  logic [3*HDR_CW-1:0]  fc_init_hdr;
  logic [3*DATA_CW-1:0] fc_init_data;
  logic                 fc_upd_valid;
  logic [1:0]           fc_upd_class;
  logic [HDR_CW-1:0]    fc_upd_hdr;
  logic [DATA_CW-1:0]   fc_upd_data;
  logic                 fc_ready, fc_overflow;

  int n_run  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  tlp_tx_arbiter #(.HDR_CW(HDR_CW), .DATA_CW(DATA_CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_fmt(req_fmt), .req_type(req_type), .req_len(req_len),
    .req_ready(req_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_fmt(out_fmt), .out_type(out_type),
    .out_len(out_len), .out_class(out_class),
    .fc_init_valid(fc_init_valid), .fc_init_hdr(fc_init_hdr), .fc_init_data(fc_init_data),
    .fc_upd_valid(fc_upd_valid), .fc_upd_class(fc_upd_class), .fc_upd_hdr(fc_upd_hdr),
    .fc_upd_data(fc_upd_data), .fc_ready(fc_ready), .fc_overflow(fc_overflow)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic samp;
    @(negedge clk);
  endtask

  task automatic set_req(input int c, input logic [2:0] f, input logic [4:0] t, input logic [9:0] l);
    req_fmt[3*c +: 3]   = f;
    req_type[5*c +: 5]  = t;
    req_len[10*c +: 10] = l;
    req_valid[c]        = 1'b1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0; req_valid = '0; fc_upd_valid = 1'b0; fc_init_valid = 1'b0;
    tick; tick;
    rst_n = 1'b1;
  endtask

  task automatic do_init(input logic [3*HDR_CW-1:0] h, input logic [3*DATA_CW-1:0] d);
    fc_init_hdr = h; fc_init_data = d; fc_init_valid = 1'b1;
    tick;
    fc_init_valid = 1'b0;
  endtask

  task automatic do_upd(input logic [1:0] c, input logic [HDR_CW-1:0] h, input logic [DATA_CW-1:0] d);
    fc_upd_valid = 1'b1; fc_upd_class = c; fc_upd_hdr = h; fc_upd_data = d;
    tick;
    fc_upd_valid = 1'b0;
  endtask

  // Single request on class c with out_ready high; ends in the following IDLE cycle.
  task automatic grant1(input string tag, input int c, input logic [2:0] f, input logic [4:0] t,
                        input logic [9:0] l);
    logic [2:0] e;
    e = 3'(1 << c);
    set_req(c, f, t, l);
    samp; chk({tag, "_rdy"}, 32'(req_ready), 32'(e));
    tick; req_valid[c] = 1'b0;
    samp;
    chk({tag, "_vld"},   32'(out_valid), 32'd1);
    chk({tag, "_class"}, 32'(out_class), 32'(c));
    chk({tag, "_fmt"},   32'(out_fmt),   32'(f));
    chk({tag, "_type"},  32'(out_type),  32'(t));
    chk({tag, "_len"},   32'(out_len),   32'(l));
    tick;
  endtask

  initial begin
    logic [2:0] e;
    rst_n = 1'b0; req_valid = '0; req_fmt = '0; req_type = '0; req_len = '0;
    out_ready = 1'b1; fc_init_valid = 1'b0; fc_init_hdr = '0; fc_init_data = '0;
    fc_upd_valid = 1'b0; fc_upd_class = '0; fc_upd_hdr = '0; fc_upd_data = '0;

    // Reset state
    tick; tick; samp;
    chk("rst_vld",   32'(out_valid),   32'd0);
    chk("rst_rdy",   32'(req_ready),   32'd0);
    chk("rst_fcrdy", 32'(fc_ready),    32'd0);
    chk("rst_ovf",   32'(fc_overflow), 32'd0);
    chk("rst_out",   32'({out_fmt, out_type, out_len, out_class}), 32'd0);
    tick; rst_n = 1'b1;

    // Basic P MWr: len 8 needs 2 data credits, 1 header credit
    do_init({8'd4, 8'd4, 8'd4}, {12'd16, 12'd0, 12'd16});
    samp; chk("t1_fcrdy", 32'(fc_ready), 32'd1); tick;
    grant1("t1", 0, FMT_3DW_DATA, TYPE_MRD, 10'd8);
    samp;
    chk("t1_pdata", 32'(dut.g_cls[0].u_data.cnt_q), 32'd14);
    chk("t1_phdr",  32'(dut.g_cls[0].u_hdr.cnt_q),  32'd3);
    tick;

    // Round robin, all classes held valid, out_ready high
    do_reset;
    do_init({8'd50, 8'd50, 8'd50}, '0);
    set_req(0, FMT_3DW_NODATA, TYPE_MRD, 10'd1);
    set_req(1, FMT_3DW_NODATA, TYPE_MRD, 10'd2);
    set_req(2, FMT_3DW_NODATA, TYPE_CPL, 10'd3);
    for (int i = 0; i < 8; i++) begin
      samp;
      if (i % 2 == 0) begin
        e = 3'(1 << ((i / 2) % 3));
        chk($sformatf("t2_rdy%0d", i), 32'(req_ready), 32'(e));
        chk($sformatf("t2_vld%0d", i), 32'(out_valid), 32'd0);
      end else begin
        chk($sformatf("t2_vld%0d", i),   32'(out_valid), 32'd1);
        chk($sformatf("t2_class%0d", i), 32'(out_class), 32'(((i - 1) / 2) % 3));
      end
      tick;
    end
    req_valid = '0;
    samp; chk("t2_phdr", 32'(dut.g_cls[0].u_hdr.cnt_q), 32'd48); tick;

    // P out of header credits must not block NP; update revives P
    do_reset;
    do_init({8'd4, 8'd4, 8'd1}, '0);
    grant1("t3a", 0, FMT_3DW_NODATA, TYPE_MRD, 10'd1);
    grant1("t3b", 2, FMT_3DW_NODATA, TYPE_CPL, 10'd0);
    set_req(0, FMT_3DW_NODATA, TYPE_MRD, 10'd4);
    set_req(1, FMT_3DW_NODATA, TYPE_MRD, 10'd5);
    samp; chk("t3_np_rdy", 32'(req_ready), 32'b010);
    tick; req_valid[1] = 1'b0;
    fc_upd_valid = 1'b1; fc_upd_class = 2'd0; fc_upd_hdr = 8'd1; fc_upd_data = '0;
    samp;
    chk("t3_np_class", 32'(out_class), 32'd1);
    chk("t3_send_rdy", 32'(req_ready), 32'd0);
    tick; fc_upd_valid = 1'b0;
    samp; chk("t3_p_rdy", 32'(req_ready), 32'b001);
    tick; req_valid = '0;
    samp;
    chk("t3_p_class", 32'(out_class), 32'd0);
    chk("t3_phdr",    32'(dut.g_cls[0].u_hdr.cnt_q), 32'd0);
    tick;

    // CplD len 0 needs 256 data credits
    do_reset;
    do_init({8'd4, 8'd4, 8'd4}, {12'd255, 12'd16, 12'd16});
    set_req(2, FMT_3DW_DATA, TYPE_CPL, 10'd0);
    samp; chk("t4_stall0", 32'(req_ready), 32'd0); tick;
    samp; chk("t4_stall1", 32'(req_ready), 32'd0); tick;
    fc_upd_valid = 1'b1; fc_upd_class = 2'd2; fc_upd_hdr = '0; fc_upd_data = 12'd1;
    samp; chk("t4_stall2", 32'(req_ready), 32'd0);
    tick; fc_upd_valid = 1'b0;
    samp; chk("t4_rdy", 32'(req_ready), 32'b100);
    tick; req_valid = '0;
    samp;
    chk("t4_class", 32'(out_class), 32'd2);
    chk("t4_len",   32'(out_len),   32'd0);
    chk("t4_cdata", 32'(dut.g_cls[2].u_data.cnt_q), 32'd0);
    tick;

    // Backpressure holds the header; reset mid-SEND drops it
    out_ready = 1'b0;
    set_req(0, FMT_3DW_NODATA, TYPE_MRD, 10'd5);
    set_req(1, FMT_3DW_NODATA, TYPE_MRD, 10'd7);
    samp; chk("t5_rdy", 32'(req_ready), 32'b001);
    tick; req_valid[0] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      samp;
      chk($sformatf("t5_vld%0d", i), 32'(out_valid), 32'd1);
      chk($sformatf("t5_len%0d", i), 32'(out_len),   32'd5);
      chk($sformatf("t5_rdy%0d", i), 32'(req_ready), 32'd0);
      tick;
    end
    samp; chk("t5_phdr", 32'(dut.g_cls[0].u_hdr.cnt_q), 32'd3); tick;
    rst_n = 1'b0; req_valid = '0;
    samp; chk("t5_rst_rdy", 32'(req_ready), 32'd0);
    tick;
    samp;
    chk("t5_rst_vld",   32'(out_valid), 32'd0);
    chk("t5_rst_fcrdy", 32'(fc_ready),  32'd0);
    chk("t5_rst_phdr",  32'(dut.g_cls[0].u_hdr.cnt_q),  32'd0);
    chk("t5_rst_pdata", 32'(dut.g_cls[0].u_data.cnt_q), 32'd0);
    tick; rst_n = 1'b1; out_ready = 1'b1;

    // Saturating update, ignored re-init, infinite NP data
    do_init({8'd4, 8'd4, 8'd100}, {12'd16, 12'd0, 12'd16});
    do_upd(2'd0, 8'd200, 12'd0);
    samp;
    chk("t6_phdr", 32'(dut.g_cls[0].u_hdr.cnt_q), 32'd255);
    chk("t6_ovf",  32'(fc_overflow), 32'd1);
    tick;
    do_init({8'd9, 8'd9, 8'd9}, {12'd9, 12'd9, 12'd9});
    samp; chk("t6_reinit", 32'(dut.g_cls[0].u_hdr.cnt_q), 32'd255); tick;
    grant1("t6a", 1, FMT_3DW_DATA, TYPE_MRD, 10'd0);
    grant1("t6b", 1, FMT_4DW_DATA, TYPE_MRD, 10'd0);
    grant1("t6c", 1, FMT_3DW_DATA, TYPE_MRD, 10'd64);
    samp;
    chk("t6_npdata", 32'(dut.g_cls[1].u_data.cnt_q), 32'd0);
    chk("t6_nphdr",  32'(dut.g_cls[1].u_hdr.cnt_q),  32'd1);
    chk("t6_ovf2",   32'(fc_overflow), 32'd1);
    tick;

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
